// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side trigger, memory router read path and PPU OAM write port of the sprite DMA.
interface oam_dma_if;
    logic        tick;
    logic [15:0] ea;
    logic [7:0]  din;
    logic        wreq;
    logic [7:0]  oam_base;
    logic [7:0]  rd_data;
    logic        CE;
    logic        busy;
    logic        dma_rd;
    logic [15:0] rd_addr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_we;

    modport master (
        input  tick, ea, din, wreq, oam_base, rd_data,
        output CE, busy, dma_rd, rd_addr, oam_addr, oam_data, oam_we
    );

    modport slave (
        output tick, ea, din, wreq, oam_base, rd_data,
        input  CE, busy, dma_rd, rd_addr, oam_addr, oam_data, oam_we
    );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: copies a 256-byte CPU page into PPU OAM while holding the CPU halted via CE.
module oam_dma #(
    parameter logic [15:0] DMA_PORT = 16'h4014
) (
    input logic        clk,
    input logic        RESET_N,
    oam_dma_if.master  bus
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t      r_state, w_state;
    logic        r_odd, w_odd, r_ce, w_ce, r_busy, w_busy, r_rd, w_rd, r_we, w_we;
    logic [7:0]  r_page, w_page, r_base, w_base, r_idx, w_idx, r_oa, w_oa, r_od, w_od;
    logic [15:0] r_ra, w_ra;

    always_comb begin
        w_state = r_state;
        w_odd   = r_odd ^ bus.tick;
        w_ce    = r_ce;
        w_busy  = r_busy;
        w_rd    = r_rd;
        w_we    = 1'b0;
        w_page  = r_page;
        w_base  = r_base;
        w_idx   = r_idx;
        w_oa    = r_oa;
        w_od    = r_od;
        w_ra    = r_ra;
        if (bus.tick) begin
            case (r_state)
                IDLE: if (bus.wreq && bus.ea == DMA_PORT) begin
                    w_page  = bus.din;
                    w_base  = bus.oam_base;
                    w_idx   = 8'd0;
                    w_ce    = 1'b0;
                    w_busy  = 1'b1;
                    w_state = HALT;
                end
                HALT:  w_state = r_odd ? ALIGN : READ;
                ALIGN: w_state = READ;
                READ: begin
                    w_rd    = 1'b1;
                    w_ra    = {r_page, r_idx};
                    w_state = WRITE;
                end
                WRITE: begin
                    w_od    = bus.rd_data;
                    w_oa    = r_base + r_idx;
                    w_we    = 1'b1;
                    w_idx   = r_idx + 8'd1;
                    w_state = (r_idx == 8'hFF) ? IDLE : READ;
                    // Release on the last byte, coincident with its write strobe
                    if (r_idx == 8'hFF) begin
                        w_ce   = 1'b1;
                        w_busy = 1'b0;
                        w_rd   = 1'b0;
                    end
                end
                default: w_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_odd   <= 1'b0;
            r_ce    <= 1'b1;
            r_busy  <= 1'b0;
            r_rd    <= 1'b0;
            r_we    <= 1'b0;
            r_page  <= 8'd0;
            r_base  <= 8'd0;
            r_idx   <= 8'd0;
            r_oa    <= 8'd0;
            r_od    <= 8'd0;
            r_ra    <= 16'd0;
        end else begin
            r_state <= w_state;
            r_odd   <= w_odd;
            r_ce    <= w_ce;
            r_busy  <= w_busy;
            r_rd    <= w_rd;
            r_we    <= w_we;
            r_page  <= w_page;
            r_base  <= w_base;
            r_idx   <= w_idx;
            r_oa    <= w_oa;
            r_od    <= w_od;
            r_ra    <= w_ra;
        end
    end

    assign bus.CE       = r_ce;
    assign bus.busy     = r_busy;
    assign bus.dma_rd   = r_rd;
    assign bus.rd_addr  = r_ra;
    assign bus.oam_addr = r_oa;
    assign bus.oam_data = r_od;
    assign bus.oam_we   = r_we;
endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite DMA engine between the 6502 core and the PPU sprite memory. A CPU write to $4014 starts the transfer. The block halts the CPU through its CE input, copies 256 bytes from CPU page $XX00–$XXFF into PPU OAM, then releases the CPU. Everything runs in the 100 MHz `clk` domain; CPU cycles are marked by a one-clock `tick` strobe.

## Interface

Parameters:
- `DMA_PORT`, default 16'h4014: CPU write address that triggers DMA.

Ports:
- `clk` input 1: 100 MHz system clock; the only clock.
- `RESET_N` input 1: synchronous, active-low reset.
- `tick` input 1: one-`clk`-wide pulse per CPU cycle, on the CLKCPU falling edge (write phase). Pulses are at least 3 `clk` apart.
- `ea` input 16: CPU effective write address (EAWR).
- `din` input 8: CPU write data (DOUT).
- `wreq` input 1: CPU write request.
- `oam_base` input 8: current PPU OAMADDR; sampled at trigger.
- `rd_data` input 8: memory router read data for `rd_addr`.
- `CE` output 1: CPU clock enable; 0 halts the CPU.
- `busy` output 1: DMA in progress.
- `dma_rd` output 1: 1 = memory router address mux selects `rd_addr` instead of the CPU address.
- `rd_addr` output 16: DMA source address.
- `oam_addr` output 8: OAM write address.
- `oam_data` output 8: OAM write data.
- `oam_we` output 1: OAM write strobe, one `clk` wide.

## Operation

- **Parity flop `odd`:** toggles on every `tick`; reset value 0.
- **Latches at trigger:**
  - `page` (8 b) loads `din`.
  - `base` (8 b) loads `oam_base`.
- **Counter:** `idx` (8 b).
- **State machine** (all transitions occur only on `tick`, except reset):
  - **IDLE:** when `wreq` && `ea == DMA_PORT` && `tick`: latch `page` and `base`, set `idx` = 0, `CE` = 0, `busy` = 1, go to HALT. `wreq` without `tick` has no effect.
  - **HALT:** go to ALIGN if `odd` = 1 at this tick, otherwise go to READ.
  - **ALIGN:** one dummy cycle, then go to READ.
  - **READ:** set `dma_rd` = 1 and `rd_addr` = {`page`, `idx`}, go to WRITE.
  - **WRITE:**
    - `oam_data` ← `rd_data`; `oam_addr` ← `base + idx` (8-bit, wraps mod 256).
    - `oam_we` = 1 for exactly the next `clk`.
    - If `idx` == 8'hFF: go to IDLE with `CE` = 1, `busy` = 0, `dma_rd` = 0. Otherwise `idx` ← `idx` + 1 and go to READ.
- `rd_addr` is held stable from the READ tick through the WRITE tick, so synchronous RAM/ROM data is valid at the WRITE tick.
- **Writes during DMA:** a write to `DMA_PORT` while `busy` = 1 is ignored (the CPU is halted, but this is defensive).
- **Source range:** the source page may be any value (SRAM, PPU regs, ROM). The block never masks it; `rd_addr` high byte is always `page`.
- **Reset** (`RESET_N` = 0 at a `clk` edge) applies in any state. Next-`clk` outputs:
  - `CE` = 1, `busy` = 0, `dma_rd` = 0, `oam_we` = 0.
  - `rd_addr` = 0, `oam_addr` = 0, `oam_data` = 0.
  - state = IDLE, `idx` = 0, `odd` = 0.

## Timing

- **Trigger to halt:** `CE` falls in the `clk` cycle after the trigger tick. The CPU completes its write cycle and stalls from the next CPU cycle.
- **Transfer length:** `CE` stays low for exactly 513 ticks with even alignment, or 514 ticks when HALT sees `odd` = 1. Breakdown: 1 HALT + 0/1 ALIGN + 256 × (READ + WRITE).
- **Write strobes:** exactly 256 `oam_we` pulses per transfer. Each is asserted the `clk` after a WRITE tick, and `oam_addr`/`oam_data` are valid while it is asserted.
- **Release:** `CE` rises the `clk` after the final WRITE tick, coincident with the last `oam_we`.
- **Back-to-back:** a new trigger is accepted on the first tick after returning to IDLE.

## Test plan

- **Even alignment:** `odd` = 0, write $4014 = 8'h02, source RAM[$0200 + i] = i ^ 8'h5A → `CE` low for 513 ticks; 256 `oam_we` pulses with `oam_addr` = i, `oam_data` = i ^ 8'h5A; `busy` ends 0.
- **Odd alignment:** same as above with `odd` = 1 at the HALT tick → `CE` low for 514 ticks; the first READ occurs one tick later; data identical.
- **OAM address wrap:** `oam_base` = 8'hF8, page 8'h07 → first write at `oam_addr` 8'hF8 with RAM[$0700]; address 8'hFF is followed by 8'h00; last write at 8'hF7 with RAM[$07FF].
- **Non-triggers:**
  - `wreq` with `ea` = 16'h4015, or `ea` = 16'h4014 with no `tick` → `CE` stays 1, no `oam_we`.
  - A second $4014 write mid-transfer → ignored; `page` unchanged.
- **Reset mid-transfer:** assert `RESET_N` = 0 after byte 100 → next `clk`: `CE` = 1, `busy` = 0, `dma_rd` = 0, `oam_we` = 0, all addresses 0. After release, a new $4014 write starts from `idx` = 0 and runs 513/514 ticks.
- **Back-to-back:** two triggers on pages 8'h02 then 8'h03, with the second issued on the first tick after release → second transfer completes with correct data; no lost or duplicated `oam_we`.
